// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit with a valid/ready handshake, zero flag,
// popcount and a passthrough tag. Holds at most two bundles, one per stage.
module bitwise_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CW-1:0]    out_ones,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        OP_NOT_B = 3'b000,
        OP_AND   = 3'b001,
        OP_OR    = 3'b010,
        OP_XOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_XNOR  = 3'b110,
        OP_ANDN  = 3'b111
    } op_e;

    function automatic logic op_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op_e'(op))
            OP_NOT_B: r = ~b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            default:  r = a & ~b;
        endcase
        return r;
    endfunction

    // Stage 1 state
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [2:0]       s1_op_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    // Stage 2 state (drives the outputs directly)
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_zero_reg;
    logic [CW-1:0]    out_ones_reg;
    logic [TAG_W-1:0] out_tag_reg;

    logic [WIDTH-1:0] result_next;
    logic [CW-1:0]    ones_next;
    logic             zero_next;

    logic s2_adv;
    logic s1_adv;
    logic in_xfer;
    logic s2_load;

    // A stage may advance when it is empty or its contents leave this cycle.
    assign s2_adv  = ~out_valid_reg | out_ready;
    assign s1_adv  = ~s1_valid_reg | s2_adv;
    assign in_ready = s1_adv & ~reset;
    assign in_xfer = in_valid & in_ready;
    assign s2_load = s1_valid_reg & s2_adv;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign result_next[gi] = op_bit(s1_op_reg, s1_a_reg[gi], s1_b_reg[gi]);
        end
    endgenerate

    always_comb begin
        ones_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_next = ones_next + CW'(result_next[i]);
        end
    end

    assign zero_next = ~|result_next;

    // Operand registers carry no valid meaning of their own, so they skip reset.
    always_ff @(posedge clock) begin
        if (in_xfer) begin
            s1_a_reg   <= in_a;
            s1_b_reg   <= in_b;
            s1_op_reg  <= in_op;
            s1_tag_reg <= in_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_zero_reg  <= 1'b0;
            out_ones_reg  <= '0;
            out_tag_reg   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
            end
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
            end
            if (s2_load) begin
                out_data_reg <= result_next;
                out_zero_reg <= zero_next;
                out_ones_reg <= ones_next;
                out_tag_reg  <= s1_tag_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_zero  = out_zero_reg;
    assign out_ones  = out_ones_reg;
    assign out_tag   = out_tag_reg;

endmodule
